maxnet_data_buffer: RTL and testbench
=====================================

# maxnet_data_buffer

Parametrised operand store for the Maxnet datapath. It holds DEPTH signed words of XLEN bits, filled serially through a valid/ready load port, and exposes all words in parallel to the Maxnet processing elements. It accepts a full-vector writeback once per iteration and reports the count of surviving (positive) entries and a single-winner flag to the Maxnet controller. It replaces the fixed four-entry, file-initialised data memory; contents are now loaded at run time.

## Interface
Parameters:
- XLEN, 32, word width in bits; stored values are two's-complement signed.
- DEPTH, 4, number of entries; must be ≥ 2. Derived: AW = $clog2(DEPTH), CW = $clog2(DEPTH+1).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous soft clear; returns the block to LOAD.
- load_valid  in  1  load word present.
- load_data  in  XLEN  load word.
- load_ready  out  1  block accepts a load word.
- wb_en  in  1  parallel writeback strobe.
- wb_data  in  XLEN*DEPTH  writeback vector; entry i is at [i*XLEN +: XLEN].
- read_data  out  XLEN*DEPTH  stored vector, same packing.
- loaded  out  1  all DEPTH words are present (state READY).
- pos_count  out  CW  number of entries that are signed > 0.
- single_winner  out  1  loaded && pos_count == 1.
- wb_count  out  16  writebacks accepted since entering READY; saturates at 16'hFFFF.

## Operation
- Two states: LOAD and READY.
- Reset (rst=1) puts the block in LOAD, sets the load index to 0, and zeroes all entries and wb_count.
  - Outputs after reset: read_data=0, loaded=0, load_ready=1, pos_count=0, single_winner=0, wb_count=0.
- clear=1 has the same effect as rst. rst and clear both take priority over load and wb_en in the same cycle.
- LOAD state:
  - load_ready=1.
  - A transfer occurs when load_valid && load_ready. The word is written to entry[idx] and idx increments.
  - The transfer at idx=DEPTH-1 moves the block to READY, resets idx to 0, and resets wb_count to 0.
  - wb_en is ignored in LOAD.
- READY state:
  - load_ready=0; load_valid is ignored.
  - wb_en=1 writes all DEPTH entries from wb_data and increments wb_count, saturating at 16'hFFFF.
  - The block stays in READY until rst or clear.
- pos_count is combinational from the stored entries. Zero and negative entries do not count. It is valid in both states.
- single_winner is forced to 0 in LOAD.

## Timing
- A load word or writeback on edge N appears on read_data, pos_count and single_winner after edge N, with zero additional latency.
- loaded rises in the cycle after the last load transfer. load_ready falls in the same cycle.
- A full load takes exactly DEPTH accepted transfers. Gaps (load_valid=0) stall idx with no penalty.
- wb_en may be asserted every cycle in READY, giving one writeback per cycle.
- Reset or clear mid-load discards the partial load: idx returns to 0 and contents are zeroed.
- Reset or clear asserted together with the final load transfer: the transfer is dropped and the state remains LOAD.

## Structure
- Package maxnet_pkg holds:
  - XLEN default.
  - The state encoding typedef (LOAD=0, READY=1).
  - The wb_count width and saturation constant.
- Sub-module maxnet_pos_count: combinational count of positive signed entries over the packed vector, parameterised on XLEN and DEPTH. It is reused by the controller's convergence check.

## Test plan
- Reset then load with DEPTH=4, words 5, 3, -2, 7 (valid every cycle) -> loaded rises after the 4th edge; read_data entries are {5, 3, -2, 7}; pos_count=3; single_winner=0.
- Load with load_valid toggling 1,0,1,0 -> exactly 4 accepted words in order; loaded is not asserted early; load_ready is held 1 throughout LOAD.
- In READY, wb_en with {0, 0, 9, -1} -> pos_count=1, single_winner=1, wb_count=1 on the next cycle.
- wb_en pulsed during LOAD, and load_valid driven during READY -> no change to contents or wb_count.
- clear asserted together with the 3rd load word, then a fresh load of 1, 2, 3, 4 -> contents are zeroed, then {1, 2, 3, 4}; wb_count=0.
- Run 65540 consecutive writebacks -> wb_count saturates at 16'hFFFF.
- Repeat the load case with DEPTH=8 and XLEN=16 -> packing at [i*16 +: 16] is correct; pos_count width is 4.

Source files
------------

// File: rtl/maxnet_pkg.sv
// Shared types and constants for the Maxnet datapath blocks.
package maxnet_pkg;

    localparam int unsigned XlenDefault = 32;

    typedef enum logic {
        StLoad  = 1'b0,
        StReady = 1'b1
    } state_e;

    localparam int unsigned WbCountW = 16;
    localparam logic [WbCountW-1:0] WbCountMax = 16'hFFFF;

endpackage

// File: rtl/maxnet_data_buffer_if.sv
// Load / writeback / status bundle between the Maxnet controller and its operand store.
interface maxnet_data_buffer_if #(
    parameter int unsigned XLEN  = maxnet_pkg::XlenDefault,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic                  load_valid;
    logic [XLEN-1:0]       load_data;
    logic                  load_ready;
    logic                  wb_en;
    logic [XLEN*DEPTH-1:0] wb_data;
    logic [XLEN*DEPTH-1:0] read_data;
    logic                  loaded;
    logic [CW-1:0]         pos_count;
    logic                  single_winner;
    logic [maxnet_pkg::WbCountW-1:0] wb_count;

    modport master (
        output load_valid, load_data, wb_en, wb_data,
        input  load_ready, read_data, loaded, pos_count, single_winner, wb_count
    );

    modport slave (
        input  load_valid, load_data, wb_en, wb_data,
        output load_ready, read_data, loaded, pos_count, single_winner, wb_count
    );

endinterface

// File: rtl/maxnet_pos_count.sv
// Counts entries of a packed signed vector that are strictly greater than zero.
module maxnet_pos_count #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic [XLEN*DEPTH-1:0] data,
    output logic [CW-1:0]         count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            // Positive means sign bit clear and not all-zero.
            if (!data[i*XLEN + XLEN - 1] && (|data[i*XLEN +: XLEN])) begin
                count = count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/maxnet_data_buffer.sv
// Maxnet operand store: serial load, parallel writeback, positive-entry status.
module maxnet_data_buffer
    import maxnet_pkg::*;
#(
    parameter int unsigned XLEN  = XlenDefault,
    parameter int unsigned DEPTH = 4
) (
    input logic clk,
    input logic rst,
    input logic clear,
    maxnet_data_buffer_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    state_e                state_q, state_d;
    logic [AW-1:0]         idx_q, idx_d;
    logic [XLEN*DEPTH-1:0] mem_q, mem_d;
    logic [WbCountW-1:0]   wb_cnt_q, wb_cnt_d;
    logic [CW-1:0]         pos;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StLoad;
            idx_q    <= '0;
            mem_q    <= '0;
            wb_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            mem_q    <= mem_d;
            wb_cnt_q <= wb_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        mem_d    = mem_q;
        wb_cnt_d = wb_cnt_q;
        if (clear) begin
            state_d  = StLoad;
            idx_d    = '0;
            mem_d    = '0;
            wb_cnt_d = '0;
        end else begin
            unique case (state_q)
                StLoad: begin
                    if (bus.load_valid) begin
                        mem_d[idx_q*XLEN +: XLEN] = bus.load_data;
                        if (idx_q == AW'(DEPTH - 1)) begin
                            state_d  = StReady;
                            idx_d    = '0;
                            wb_cnt_d = '0;
                        end else begin
                            idx_d = idx_q + AW'(1);
                        end
                    end
                end
                StReady: begin
                    if (bus.wb_en) begin
                        mem_d = bus.wb_data;
                        if (wb_cnt_q != WbCountMax) begin
                            wb_cnt_d = wb_cnt_q + WbCountW'(1);
                        end
                    end
                end
            endcase
        end
    end

    maxnet_pos_count #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_pos_count (
        .data  (mem_q),
        .count (pos)
    );

    always_comb begin
        bus.load_ready    = 1'b0;
        bus.loaded        = 1'b0;
        unique case (state_q)
            StLoad:  bus.load_ready = 1'b1;
            StReady: bus.loaded     = 1'b1;
        endcase
        bus.read_data     = mem_q;
        bus.pos_count     = pos;
        bus.single_winner = (state_q == StReady) && (pos == CW'(1));
        bus.wb_count      = wb_cnt_q;
    end

endmodule

// File: tb/tb_maxnet_data_buffer.sv
// Randomised bench for maxnet_data_buffer against a queue-based reference model.
module tb_maxnet_data_buffer;

    logic clk = 1'b0;
    logic rst_a, clear_a, rst_b, clear_b;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    maxnet_data_buffer_if #(.XLEN(32), .DEPTH(4)) bus_a ();
    maxnet_data_buffer_if #(.XLEN(16), .DEPTH(8)) bus_b ();

    maxnet_data_buffer #(.XLEN(32), .DEPTH(4)) u_dut_a (
        .clk   (clk),
        .rst   (rst_a),
        .clear (clear_a),
        .bus   (bus_a)
    );

    maxnet_data_buffer #(.XLEN(16), .DEPTH(8)) u_dut_b (
        .clk   (clk),
        .rst   (rst_b),
        .clear (clear_b),
        .bus   (bus_b)
    );

    task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference model for DUT A: words collect in a queue until a full vector is present.
    int m_mem[4];
    int m_pending[$];
    bit m_ready;
    int m_wb;

    function automatic void model_a(bit clr, bit lv, logic [31:0] ld, bit we,
                                    logic [127:0] wd);
        if (clr) begin
            foreach (m_mem[i]) m_mem[i] = 0;
            m_pending.delete();
            m_ready = 0;
            m_wb    = 0;
        end else if (!m_ready) begin
            if (lv) begin
                m_pending.push_back(int'($signed(ld)));
                m_mem[m_pending.size() - 1] = int'($signed(ld));
                if (m_pending.size() == 4) begin
                    m_ready = 1;
                    m_wb    = 0;
                    m_pending.delete();
                end
            end
        end else if (we) begin
            for (int i = 0; i < 4; i++) m_mem[i] = int'($signed(wd[i*32 +: 32]));
            if (m_wb < 65535) m_wb = m_wb + 1;
        end
    endfunction

    task automatic check_a(string tag);
        logic [127:0] v;
        int           p;
        p = 0;
        for (int i = 0; i < 4; i++) begin
            v[i*32 +: 32] = m_mem[i];
            if (m_mem[i] > 0) p++;
        end
        check({tag, ".read_data"}, bus_a.read_data, v);
        check({tag, ".loaded"}, 128'(bus_a.loaded), 128'(m_ready));
        check({tag, ".load_ready"}, 128'(bus_a.load_ready), 128'(!m_ready));
        check({tag, ".pos_count"}, 128'(bus_a.pos_count), 128'(p));
        check({tag, ".single_winner"}, 128'(bus_a.single_winner), 128'(m_ready && p == 1));
        check({tag, ".wb_count"}, 128'(bus_a.wb_count), 128'(m_wb));
    endtask

    task automatic step_a(string tag, bit r, bit c, bit lv, logic [31:0] ld, bit we,
                          logic [127:0] wd);
        rst_a              = r;
        clear_a            = c;
        bus_a.load_valid   = lv;
        bus_a.load_data    = ld;
        bus_a.wb_en        = we;
        bus_a.wb_data      = wd;
        @(posedge clk);
        model_a(r | c, lv, ld, we, wd);
        #1;
        check_a(tag);
    endtask

    function automatic logic [127:0] pack4(int e0, int e1, int e2, int e3);
        logic [127:0] v;
        v[31:0] = e0; v[63:32] = e1; v[95:64] = e2; v[127:96] = e3;
        return v;
    endfunction

    function automatic logic [31:0] small_word();
        return 32'(int'($urandom_range(0, 6)) - 3);
    endfunction

    int dir_words[4] = '{5, 3, -2, 7};
    int seq_words[4] = '{1, 2, 3, 4};

    initial begin
        logic [127:0] wd;
        logic [127:0] vb;
        logic [15:0]  wb_words[8];
        int           pb;

        rst_b = 1'b1; clear_b = 1'b0;
        bus_b.load_valid = 1'b0; bus_b.load_data = '0; bus_b.wb_en = 1'b0; bus_b.wb_data = '0;

        step_a("reset", 1, 0, 0, 0, 0, '0);

        for (int i = 0; i < 4; i++) step_a("load", 0, 0, 1, 32'(dir_words[i]), 0, '0);
        step_a("ready_idle", 0, 0, 0, 0, 0, '0);

        step_a("wb_single", 0, 0, 0, 0, 1, pack4(0, 0, 9, -1));
        step_a("ld_in_ready", 0, 0, 1, 32'd77, 0, '0);

        step_a("rst2", 1, 0, 0, 0, 0, '0);
        for (int i = 0; i < 8; i++) begin
            step_a("toggle", 0, 0, (i % 2) == 0, 32'(10 + i), 0, '0);
        end
        step_a("wb_after_toggle", 0, 0, 0, 0, 1, pack4(-4, 6, 0, 2));

        step_a("clr", 0, 1, 0, 0, 0, '0);
        step_a("wb_in_load", 0, 0, 0, 0, 1, pack4(8, 8, 8, 8));
        step_a("ld1", 0, 0, 1, 32'd11, 0, '0);
        step_a("ld2", 0, 0, 1, 32'd12, 1, pack4(8, 8, 8, 8));
        step_a("clr_with_ld3", 0, 1, 1, 32'd13, 0, '0);
        for (int i = 0; i < 4; i++) step_a("fresh", 0, 0, 1, 32'(seq_words[i]), 0, '0);

        // Final transfer dropped when clear coincides with it.
        step_a("clr3", 0, 1, 0, 0, 0, '0);
        for (int i = 0; i < 3; i++) step_a("pre", 0, 0, 1, 32'(i + 1), 0, '0);
        step_a("clr_final", 0, 1, 1, 32'd4, 0, '0);
        step_a("after_clr_final", 0, 0, 0, 0, 0, '0);

        for (int n = 0; n < 2000; n++) begin
            wd = pack4(int'(small_word()), int'(small_word()), int'(small_word()),
                       int'(small_word()));
            step_a("rand", $urandom_range(0, 99) == 0, $urandom_range(0, 59) == 0,
                   $urandom_range(0, 1) == 1, small_word(), $urandom_range(0, 1) == 1, wd);
        end

        step_a("sat_rst", 1, 0, 0, 0, 0, '0);
        for (int i = 0; i < 4; i++) step_a("sat_load", 0, 0, 1, 32'(dir_words[i]), 0, '0);
        for (int n = 0; n < 65540; n++) begin
            step_a("sat", 0, 0, 0, 0, 1, pack4(n & 3, -1, 0, 1));
        end

        // Wide-depth, narrow-word instance: packing and 4-bit pos_count.
        rst_a = 1'b1;
        for (int i = 0; i < 8; i++) wb_words[i] = 16'($urandom_range(0, 65535));
        wb_words[2] = 16'h0000;
        wb_words[5] = 16'h8000;
        @(posedge clk); #1;
        rst_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("b.load_ready", 128'(bus_b.load_ready), 128'(1));
            check("b.loaded_early", 128'(bus_b.loaded), 128'(0));
            bus_b.load_valid = 1'b1;
            bus_b.load_data  = wb_words[i];
            @(posedge clk); #1;
        end
        bus_b.load_valid = 1'b0;
        vb = '0;
        pb = 0;
        for (int i = 0; i < 8; i++) begin
            vb[i*16 +: 16] = wb_words[i];
            if ($signed(wb_words[i]) > 0) pb++;
        end
        check("b.read_data", bus_b.read_data, vb);
        check("b.pos_count", 128'(bus_b.pos_count), 128'(pb));
        check("b.loaded", 128'(bus_b.loaded), 128'(1));
        check("b.single_winner", 128'(bus_b.single_winner), 128'(pb == 1));
        check("b.entry3", 128'(bus_b.read_data[3*16 +: 16]), 128'(wb_words[3]));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
